// File: rtl/cbb_pkg.sv
// Shared CBB definitions: the arbiter state encoding and a constant-safe clog2 helper.
package cbb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cbb_barrel_shifter.sv
// Rotating barrel shifter; the caller keeps shift_amount below W.
module cbb_barrel_shifter #(
  parameter int   W         = 8,
  parameter int   SHIFT_W   = 3,
  parameter logic ROT_RIGHT = 1'b1
) (
  input  logic [W-1:0]       data,
  input  logic [SHIFT_W-1:0] shift_amount,
  output logic [W-1:0]       result
);

  // Doubling the word turns a rotate into a plain shift of the concatenation.
  always_comb begin
    if (ROT_RIGHT) begin
      result = W'({data, data} >> shift_amount);
    end else begin
      result = W'(({data, data} << shift_amount) >> W);
    end
  end

endmodule

// File: rtl/cbb_rr_arbiter.sv
// Round-robin arbiter: rotate req by the pointer, pick the lowest set bit,
// and present a registered one-hot grant held until the consumer accepts it.
module cbb_rr_arbiter
  import cbb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     gnt_q, gnt_d;

  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] arb_ptr;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] low_bit;
  logic [IDX_W:0]   idx_sum;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_gnt;
  logic             any_req;
  logic             accept;

  assign accept   = (state_q == ARB_GRANT) && gnt_ready;
  assign next_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  // On accept the re-arbitration must already see the advanced pointer.
  assign arb_ptr  = accept ? next_ptr : ptr_q;
  assign any_req  = |req;

  cbb_barrel_shifter #(
    .W         (N),
    .SHIFT_W   (IDX_W),
    .ROT_RIGHT (1'b1)
  ) u_rot (
    .data         (req),
    .shift_amount (arb_ptr),
    .result       (req_rot)
  );

  always_comb begin
    low_bit = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) low_bit = IDX_W'(i);
    end
  end

  always_comb begin
    idx_sum = {1'b0, low_bit} + {1'b0, arb_ptr};
    if (idx_sum >= N_EXT) begin
      sel_idx = IDX_W'(idx_sum - N_EXT);
    end else begin
      sel_idx = IDX_W'(idx_sum);
    end
  end

  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      sel_gnt[i] = (sel_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          gnt_d   = sel_gnt;
          idx_d   = sel_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (gnt_ready) begin
          ptr_d = next_ptr;
          if (any_req) begin
            gnt_d = sel_gnt;
            idx_d = sel_idx;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_valid = (state_q == ARB_GRANT);
  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;

endmodule
